// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-port round-robin arbiter/sequencer in front of a single-port SRAM.
// Define SRAM_ARB_STATS_EN to add saturating per-port grant counters with a synchronous clear.
module sram_rr_arbiter #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [WIDTH-1:0]      a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]      b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [WIDTH-1:0]      b_rdata,
`ifdef SRAM_ARB_STATS_EN
  input  logic                  stats_clr,
  output logic [15:0]           a_gnt_cnt,
  output logic [15:0]           b_gnt_cnt,
`endif
  output logic                  mem_wr_req,
  output logic                  mem_re_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_din,
  input  logic [WIDTH-1:0]      mem_dout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic sel_b_q, sel_b_d, rr_b_q, rr_b_d, we_q, we_d, pick_b;
  logic [2:0] cnt_q, cnt_d;
  logic a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d, a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic mem_wr_req_q, mem_wr_req_d, mem_re_req_q, mem_re_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_din_q, mem_din_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  // B wins only when A is idle or A held the previous grant
  assign pick_b = b_req && (!a_req || !rr_b_q);
  always_comb begin
    state_d = state_q;
    sel_b_d = sel_b_q;
    rr_b_d = rr_b_q;
    we_d = we_q;
    cnt_d = cnt_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    mem_wr_req_d = 1'b0;
    mem_re_req_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: if (a_req || b_req) begin
        sel_b_d = pick_b;
        rr_b_d = pick_b;
        we_d = pick_b ? b_we : a_we;
        mem_addr_d = pick_b ? b_addr : a_addr;
        mem_din_d = pick_b ? b_wdata : a_wdata;
        a_gnt_d = !pick_b;
        b_gnt_d = pick_b;
        mem_wr_req_d = we_d;
        mem_re_req_d = !we_d;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        cnt_d = 3'(RD_LAT - 1);
      end
      WAIT: if (cnt_q == '0) begin
        a_rdata_d = sel_b_q ? a_rdata_q : mem_dout;
        b_rdata_d = sel_b_q ? mem_dout : b_rdata_q;
        a_rvalid_d = !sel_b_q;
        b_rvalid_d = sel_b_q;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_b_q <= 1'b0;
      rr_b_q <= 1'b1;
      we_q <= 1'b0;
      cnt_q <= '0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_re_req_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_b_q <= sel_b_d;
      rr_b_q <= rr_b_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_re_req_q <= mem_re_req_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end
  assign a_gnt = a_gnt_q;
  assign b_gnt = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_re_req = mem_re_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  // clear takes priority over a same-cycle grant
  always_comb begin
    a_cnt_d = stats_clr ? '0 : a_cnt_q + 16'(a_gnt_q && a_cnt_q != 16'hFFFF);
    b_cnt_d = stats_clr ? '0 : b_cnt_q + 16'(b_gnt_q && b_cnt_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end
  assign a_gnt_cnt = a_cnt_q;
  assign b_gnt_cnt = b_cnt_q;
`endif
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: randomized scoreboard bench for sram_rr_arbiter with a behavioural SRAM and reference memory.
module tb_sram_rr_arbiter;
  localparam int WIDTH = 4, DEPTH = 32, AW = 5, RD_LAT = 2, TMO = 400;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [WIDTH-1:0] data; logic [3:0] gap;} cmd_t;
  typedef struct packed {logic [WIDTH-1:0] data; logic [31:0] cyc;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_v [2], we_v [2];
  logic [AW-1:0] addr_v [2];
  logic [WIDTH-1:0] wdata_v [2];
  logic [1:0] gnt_w, rv_w;
  logic [WIDTH-1:0] a_rdata, b_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic mem_wr_req, mem_re_req;
`ifdef SRAM_ARB_STATS_EN
  logic stats_clr = 1'b0;
  logic [15:0] a_gnt_cnt, b_gnt_cnt, cnt_m [2];
`endif
  sram_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .a_req(req_v[0]), .a_we(we_v[0]), .a_addr(addr_v[0]), .a_wdata(wdata_v[0]),
    .a_gnt(gnt_w[0]), .a_rvalid(rv_w[0]), .a_rdata(a_rdata),
    .b_req(req_v[1]), .b_we(we_v[1]), .b_addr(addr_v[1]), .b_wdata(wdata_v[1]),
    .b_gnt(gnt_w[1]), .b_rvalid(rv_w[1]), .b_rdata(b_rdata),
`ifdef SRAM_ARB_STATS_EN
    .stats_clr(stats_clr), .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt),
`endif
    .mem_wr_req(mem_wr_req), .mem_re_req(mem_re_req), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout));
  always #5 clk = ~clk;
  logic [WIDTH-1:0] sram [DEPTH], pipe [RD_LAT];
  assign mem_dout = pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (mem_wr_req) sram[mem_addr] <= mem_din;
    pipe[0] <= sram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  int cyc = 0, total = 0, passes = 0;
  always @(posedge clk) cyc <= cyc + 1;
  cmd_t cq_a [$], cq_b [$];
  exp_t exp_a [$], exp_b [$];
  logic [WIDTH-1:0] ref_mem [DEPTH], rd_m [2];
  logic busy [2];
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction
  function automatic cmd_t mk(input logic we, input int addr, input int data, input int gap);
    return '{we: we, addr: AW'(addr), data: WIDTH'(data), gap: 4'(gap)};
  endfunction
  function automatic void push(input int p, input cmd_t c);
    if (p == 0) cq_a.push_back(c); else cq_b.push_back(c);
  endfunction
  // expected read data comes from the reference memory in grant order
  function automatic void accept(input int p, input cmd_t c);
    exp_t e;
    chk(p ? "b_gnt_wr" : "a_gnt_wr", mem_wr_req, c.we);
    chk(p ? "b_gnt_re" : "a_gnt_re", mem_re_req, !c.we);
    chk(p ? "b_gnt_addr" : "a_gnt_addr", mem_addr, c.addr);
    if (c.we) begin
      chk(p ? "b_gnt_din" : "a_gnt_din", mem_din, c.data);
      ref_mem[c.addr] = c.data;
    end else begin
      e = '{data: ref_mem[c.addr], cyc: cyc};
      if (p == 0) exp_a.push_back(e); else exp_b.push_back(e);
    end
  endfunction
  task automatic drive(input int p);
    cmd_t c;
    int t;
    forever begin
      @(posedge clk); #1;
      if ((p == 0 && cq_a.size() > 0) || (p == 1 && cq_b.size() > 0)) begin
        c = (p == 0) ? cq_a.pop_front() : cq_b.pop_front();
        busy[p] = 1'b1;
        if (c.gap != 0) begin
          req_v[p] = 1'b0;
          repeat (int'(c.gap)) @(posedge clk);
          #1;
        end
        req_v[p] = 1'b1; we_v[p] = c.we; addr_v[p] = c.addr; wdata_v[p] = c.data;
        t = 0;
        do begin @(negedge clk); t++; end while (!gnt_w[p] && t < TMO);
        if (gnt_w[p]) accept(p, c);
        else begin total++; $display("FAIL gnt_timeout port %0d: got no gnt expected gnt within %0d cycles", p, TMO); end
      end else begin
        req_v[p] = 1'b0;
        busy[p] = 1'b0;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin req_v[p] = 0; we_v[p] = 0; addr_v[p] = '0; wdata_v[p] = '0; busy[p] = 0; rd_m[p] = '0; end
    fork drive(0); drive(1); join_none
  end
  int last = 1, next_ok = 0;
  logic [1:0] prev_req = '0;
  logic prev_ok = 0, rst_prev = 0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_prev)
        chk("reset_outputs", {gnt_w, rv_w, mem_wr_req, mem_re_req, mem_addr, mem_din, a_rdata, b_rdata}, '0);
      if (mem_wr_req || mem_re_req) begin
        chk("single_strobe", mem_wr_req & mem_re_req, 0);
        chk("strobe_has_gnt", gnt_w == 2'b01 || gnt_w == 2'b10, 1);
      end
      for (int p = 0; p < 2; p++) if (gnt_w[p]) begin
        chk("gnt_had_req", prev_ok && prev_req[p], 1);
        if (prev_req == 2'b11) chk("rr_winner", p, 1 - last);
        chk("gnt_not_busy", cyc >= next_ok, 1);
        last = p;
        next_ok = cyc + (mem_wr_req ? 2 : 3 + RD_LAT);
      end
      for (int p = 0; p < 2; p++) if (rv_w[p]) begin
        if ((p == 0 ? exp_a.size() : exp_b.size()) == 0) begin
          total++;
          $display("FAIL spurious_rvalid port %0d: got rvalid expected none", p);
        end else begin
          e = (p == 0) ? exp_a.pop_front() : exp_b.pop_front();
          chk(p ? "b_rdata" : "a_rdata", p ? b_rdata : a_rdata, e.data);
          chk(p ? "b_rvalid_lat" : "a_rvalid_lat", cyc, e.cyc + 1 + RD_LAT);
          rd_m[p] = e.data;
        end
      end
      chk("a_rdata_hold", a_rdata, rd_m[0]);
      chk("b_rdata_hold", b_rdata, rd_m[1]);
`ifdef SRAM_ARB_STATS_EN
      chk("a_gnt_cnt", a_gnt_cnt, cnt_m[0]);
      chk("b_gnt_cnt", b_gnt_cnt, cnt_m[1]);
      for (int p = 0; p < 2; p++)
        cnt_m[p] = (rst || stats_clr) ? 16'd0 : (gnt_w[p] && cnt_m[p] != 16'hFFFF) ? cnt_m[p] + 16'd1 : cnt_m[p];
`endif
      prev_req = {req_v[1], req_v[0]};
      prev_ok = !rst;
      rst_prev = rst;
      if (rst) begin
        exp_a.delete(); exp_b.delete();
        last = 1; next_ok = 0; rd_m[0] = '0; rd_m[1] = '0;
      end
    end
  end
  task automatic wait_idle();
    int t = 0;
    while ((cq_a.size() + cq_b.size() + exp_a.size() + exp_b.size()) != 0 || busy[0] || busy[1]) begin
      @(negedge clk);
      if (++t > 4000) begin
        total++;
        $display("FAIL idle_timeout: got busy expected idle after %0d cycles", t);
        break;
      end
    end
    repeat (RD_LAT + 4) @(negedge clk);
  endtask
  initial begin
    int t;
`ifdef SRAM_ARB_STATS_EN
    cnt_m[0] = '0; cnt_m[1] = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push(0, mk(1, 3, 'hA, 0)); push(0, mk(0, 3, 0, 0));
    wait_idle();
    chk("a_rdata_first", a_rdata, 4'hA);
    chk("b_rdata_untouched", b_rdata, 0);
    push(0, mk(1, 1, 5, 0)); push(1, mk(1, 2, 6, 0));
    wait_idle();
    for (int i = 0; i < 6; i++) begin push(0, mk(0, 1, 0, 0)); push(1, mk(0, 2, 0, 0)); end
    wait_idle();
    chk("a_rdata_alt", a_rdata, 5);
    chk("b_rdata_alt", b_rdata, 6);
    push(0, mk(0, 1, 0, 0));
    repeat (3) @(posedge clk);
    push(1, mk(1, 7, 3, 0)); push(1, mk(0, 7, 0, 0));
    wait_idle();
    chk("b_read_back7", b_rdata, 3);
    for (int i = 0; i < DEPTH; i++) push(i % 2, mk(1, i, i % 16, 0));
    for (int i = 0; i < DEPTH; i++) push(i % 2, mk(0, i, 0, 0));
    wait_idle();
    for (int i = 0; i < 60; i++)
      for (int p = 0; p < 2; p++)
        push(p, mk($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 15), $urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : 0));
    wait_idle();
    push(0, mk(0, 5, 0, 0));
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt_w[0] && t < TMO);
    push(0, mk(0, 9, 0, 0)); push(1, mk(0, 10, 0, 0));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (gnt_w == 2'b00 && t < TMO);
    chk("post_reset_first_gnt", gnt_w, 2'b01);
    wait_idle();
`ifdef SRAM_ARB_STATS_EN
    @(posedge clk); #1 stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    for (int i = 0; i < 5; i++) push(0, mk(1, i, i, 0));
    for (int i = 0; i < 3; i++) push(1, mk(1, 8 + i, i, 0));
    wait_idle();
    chk("a_gnt_cnt_5", a_gnt_cnt, 5);
    chk("b_gnt_cnt_3", b_gnt_cnt, 3);
    for (int i = 0; i < 6; i++) begin push(0, mk(1, i, i, 0)); push(1, mk(1, 16 + i, i, 0)); end
    @(posedge clk); #1 stats_clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin chk("clr_a_cnt", a_gnt_cnt, 0); chk("clr_b_cnt", b_gnt_cnt, 0); end
    end
    @(posedge clk); #1 stats_clr = 1'b0;
    wait_idle();
`endif
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
Two-requester round-robin arbiter and sequencer in front of a single-port sram_top instance (WIDTH x DEPTH).
- Accepts read/write commands from ports A and B using a req/gnt handshake.
- Serialises the commands onto the SRAM wr_req/re_req strobes.
- Returns read data to the originating port with an rvalid pulse.
- Lets two agents (e.g. host and DMA) share one memory without colliding.

Parameters:
WIDTH, 4, data width in bits; matches sram_top WIDTH
DEPTH, 32, number of SRAM words; matches sram_top DEPTH
ADDR_WIDTH, $clog2(DEPTH), address width (derived)
RD_LAT, 1, cycles from the re_req strobe cycle to the cycle in which sram dout_out is valid; legal range 1..7

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
a_req  in  1  port A command request; held until a_gnt seen
a_we  in  1  port A: 1 = write, 0 = read; stable while a_req
a_addr  in  ADDR_WIDTH  port A address; stable while a_req
a_wdata  in  WIDTH  port A write data; stable while a_req
a_gnt  out  1  one-cycle pulse: port A command accepted and issued
a_rvalid  out  1  one-cycle pulse: a_rdata valid
a_rdata  out  WIDTH  port A read data; holds until the next A read completes
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
mem_wr_req  out  1  to sram_top wr_req
mem_re_req  out  1  to sram_top re_req
mem_addr  out  ADDR_WIDTH  to sram_top addr_in
mem_din  out  WIDTH  to sram_top din_in
mem_dout  in  WIDTH  from sram_top dout_out

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and named rst. While rst=1 at a rising edge, the following take effect next cycle:
  - state=IDLE
  - all gnt, rvalid and mem_* outputs = 0
  - a_rdata = b_rdata = 0
  - rr_last = B, so A wins the first tie.
- Registered outputs: every output is registered; no combinational path from input to output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: samples a_req and b_req.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: select that port.
  - Both asserted: select the port != rr_last.
  - On selection: latch we/addr/wdata and the port ID, set rr_last = selected port, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - x_gnt=1 for the selected port only.
  - mem_addr = latched address.
  - Write: mem_wr_req=1, mem_din = latched data; next state IDLE.
  - Read: mem_re_req=1; next state WAIT.
  - Only one of mem_wr_req/mem_re_req is ever high, and never in any cycle other than ISSUE.
- WAIT: an internal counter runs RD_LAT cycles. mem_addr is held throughout. On the last WAIT cycle, mem_dout is captured into the selected port's rdata register. Next state RESP.
- RESP (1 cycle): x_rvalid=1 for the selected port only; next state IDLE.
- Latency from a req sampled in IDLE at cycle N:
  - gnt and strobe in N+1.
  - Write: next arbitration in N+2.
  - Read: rvalid in N+2+RD_LAT; next arbitration in N+3+RD_LAT.
- Requester handshake:
  - Requester deasserts req in the cycle after it sees gnt, or re-arms it for the next command.
  - A req held through the return to IDLE is treated as a new command.
- Fairness: with both ports continuously requesting, grants strictly alternate A,B,A,B...
- Back-pressure: a req arriving while state != IDLE waits; no command is dropped.
- Address: out-of-range addresses are not checked; they are passed through modulo 2^ADDR_WIDTH.
- Reset mid-operation: the FSM returns to IDLE and no pending gnt, rvalid or strobe is emitted afterwards. A write whose strobe was already issued is complete; the other port's pending req is arbitrated fresh with rr_last=B.
- rdata isolation: a_rdata and b_rdata are only updated by their own port's reads.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- When defined:
  - Adds outputs a_gnt_cnt and b_gnt_cnt, each 16 bits.
  - Each counter increments on its port's gnt and saturates at 16'hFFFF.
  - Both counters clear on rst.
  - Adds input stats_clr (1 bit), which synchronously zeroes both counters. If stats_clr and a gnt occur in the same cycle, the clear wins.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then A write addr=3 data=4'hA, then A read addr=3 -> a_gnt pulses in the cycle after each req is sampled; mem_wr_req high for exactly 1 cycle; a_rvalid pulses with a_rdata=4'hA; b_rdata stays 0, b_rvalid never asserts.
- Both ports request reads every cycle (A addr=1, B addr=2, preloaded 4'h5/4'h6) -> grant order A,B,A,B; each rvalid lands on the correct port at N+2+RD_LAT; a_rdata=5, b_rdata=6.
- B write addr=7 data=4'h3 held during an A read in WAIT -> b_gnt is not asserted until the FSM returns to IDLE; a later read of addr 7 returns 4'h3.
- Fill all 32 addresses via alternating ports (A even addresses, B odd, data=addr[3:0]), then read back all 32 -> every readback matches; no cycle has mem_wr_req and mem_re_req high together.
- Assert rst during WAIT of an A read -> a_rvalid never pulses; all outputs 0 next cycle; simultaneous A/B request after reset goes to A first.
- SRAM_ARB_STATS_EN defined: 5 A grants and 3 B grants -> a_gnt_cnt=5, b_gnt_cnt=3; stats_clr pulse zeroes both counters even with a grant in the same cycle.
